// File: rtl/if_id_hazard_reg_if.sv
// Fetch/decode boundary bundle for the IF/ID register.
// master drives fetch and EX feedback; slave is the register itself.
interface if_id_hazard_reg_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic [N-1:0]     pc_in;
  logic [N-1:0]     pc_plus4_in;
  logic [31:0]      instr_in;
  logic             instr_valid_in;
  logic             flush_in;
  logic             ex_memread_in;
  logic [4:0]       ex_rd_in;
  logic [N-1:0]     pc_out;
  logic [N-1:0]     pc_plus4_out;
  logic [31:0]      instr_out;
  logic             valid_out;
  logic [4:0]       rs1_out;
  logic [4:0]       rs2_out;
  logic             pc_write_out;
  logic             id_ex_bubble_out;
  logic [CNT_W-1:0] stall_count_out;

  modport master (
    output pc_in, pc_plus4_in, instr_in,
    output instr_valid_in, flush_in,
    output ex_memread_in, ex_rd_in,
    input  pc_out, pc_plus4_out, instr_out,
    input  valid_out, rs1_out, rs2_out,
    input  pc_write_out, id_ex_bubble_out,
    input  stall_count_out
  );

  modport slave (
    input  pc_in, pc_plus4_in, instr_in,
    input  instr_valid_in, flush_in,
    input  ex_memread_in, ex_rd_in,
    output pc_out, pc_plus4_out, instr_out,
    output valid_out, rs1_out, rs2_out,
    output pc_write_out, id_ex_bubble_out,
    output stall_count_out
  );
endinterface

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use stall, flush
// and a saturating stall counter; updates on falling clk.
module if_id_hazard_reg #(
  parameter int          N         = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input logic               clk,
  input logic               reset,
  if_id_hazard_reg_if.slave bus
);

  logic [N-1:0]     pc_q;
  logic [N-1:0]     pc4_q;
  logic [31:0]      instr_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       rd_hit;
  logic       load_use;
  logic       stall;

  assign opcode = instr_q[6:0];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    unique case (opcode)
      7'b0110111,
      7'b0010111,
      7'b1101111: uses_rs1 = 1'b0;
      7'b0110011,
      7'b0100011,
      7'b1100011: uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  // x0 as a load destination never creates a dependency
  assign rd_hit = (uses_rs1 && bus.ex_rd_in == rs1)
               || (uses_rs2 && bus.ex_rd_in == rs2);

  assign load_use = valid_q && bus.ex_memread_in
                 && (bus.ex_rd_in != 5'd0) && rd_hit;

  assign stall = load_use && !bus.flush_in;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (bus.flush_in) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (stall) begin
      pc_q    <= pc_q;
    end else if (!bus.instr_valid_in) begin
      pc_q    <= bus.pc_in;
      pc4_q   <= bus.pc_plus4_in;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= bus.pc_in;
      pc4_q   <= bus.pc_plus4_in;
      instr_q <= bus.instr_in;
      valid_q <= 1'b1;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (stall && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc_out           = pc_q;
  assign bus.pc_plus4_out     = pc4_q;
  assign bus.instr_out        = instr_q;
  assign bus.valid_out        = valid_q;
  assign bus.rs1_out          = rs1;
  assign bus.rs2_out          = rs2;
  assign bus.pc_write_out     = !stall;
  assign bus.id_ex_bubble_out = stall || bus.flush_in;
  assign bus.stall_count_out  = cnt_q;

endmodule
